// File: rtl/core_inst_pkg.sv
// Shared types and inst-word bit positions for the core instruction sequencer.
package core_inst_pkg;

    localparam int INST_W  = 35;
    localparam int SRAM_AW = 11;

    localparam int INST_RELU   = 34;
    localparam int INST_ACCUM  = 33;
    localparam int INST_PCEN   = 32;
    localparam int INST_PWEN   = 31;
    localparam int INST_PA_LSB = 20;
    localparam int INST_XCEN   = 19;
    localparam int INST_XWEN   = 18;
    localparam int INST_XA_LSB = 7;
    localparam int INST_OFRD   = 6;
    localparam int INST_L0RD   = 3;
    localparam int INST_L0WR   = 2;
    localparam int INST_EXE    = 1;
    localparam int INST_KLD    = 0;

    // Both SRAMs deselected with write disabled, every other control low.
    localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_KLD, S_KARR, S_KGAP, S_ALD, S_EXEC, S_DRN, S_FIN
    } state_t;

    typedef struct packed {
        logic               relu;
        logic               accum;
        logic               pcen;
        logic               pwen;
        logic [SRAM_AW-1:0] paddr;
        logic               xcen;
        logic               xwen;
        logic [SRAM_AW-1:0] xaddr;
        logic               ofrd;
        logic               l0rd;
        logic               l0wr;
        logic               exe;
        logic               kld;
    } inst_fields_t;

endpackage

// File: rtl/inst_word_pack.sv
// Packs decoded control fields into the 35-bit core instruction word.
module inst_word_pack
    import core_inst_pkg::*;
(
    input  inst_fields_t      f,
    output logic [INST_W-1:0] word
);

    always_comb begin
        word                            = '0;
        word[INST_RELU]                 = f.relu;
        word[INST_ACCUM]                = f.accum;
        word[INST_PCEN]                 = f.pcen;
        word[INST_PWEN]                 = f.pwen;
        word[INST_PA_LSB +: SRAM_AW]    = f.paddr;
        word[INST_XCEN]                 = f.xcen;
        word[INST_XWEN]                 = f.xwen;
        word[INST_XA_LSB +: SRAM_AW]    = f.xaddr;
        word[INST_OFRD]                 = f.ofrd;
        word[INST_L0RD]                 = f.l0rd;
        word[INST_L0WR]                 = f.l0wr;
        word[INST_EXE]                  = f.exe;
        word[INST_KLD]                  = f.kld;
    end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer: kernel load, activation load, execute and OFIFO drain per kij.
// Optional CORE_INST_SEQ_PERF_EN adds perf_cycles / perf_stall counters.
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int COL     = 8,
    parameter int ADDR_W  = 11,
    parameter int NUM_KIJ = 9,
    parameter int LEN_W   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_act_base,
    input  logic [ADDR_W-1:0] cfg_ker_base,
    input  logic [ADDR_W-1:0] cfg_psum_base,
    input  logic [LEN_W-1:0]  cfg_act_len,
    input  logic [LEN_W-1:0]  cfg_out_len,
    input  logic              cfg_relu,
    input  logic              ofifo_valid,
`ifdef CORE_INST_SEQ_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
`endif
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int KW = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic              sub_q, sub_d;
    logic              err_addr_q, err_addr_d;
    logic [ADDR_W-1:0] act_base_q, act_base_d;
    logic [ADDR_W-1:0] ker_base_q, ker_base_d;
    logic [ADDR_W-1:0] psum_base_q, psum_base_d;
    logic [LEN_W-1:0]  act_len_q, act_len_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;
    logic              relu_q, relu_d;
    logic [INST_W-1:0] inst_q, inst_d;

    inst_fields_t      fields;
    logic [15:0]       xa_full;
    logic              last_pass;
    logic              drain_step;

    assign last_pass = (k_q == KW'(NUM_KIJ - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        j_d         = j_q;
        k_d         = k_q;
        sub_d       = sub_q;
        err_addr_d  = err_addr_q;
        act_base_d  = act_base_q;
        ker_base_d  = ker_base_q;
        psum_base_d = psum_base_q;
        act_len_d   = act_len_q;
        out_len_d   = out_len_q;
        relu_d      = relu_q;
        drain_step  = 1'b0;
        fields      = '0;
        fields.pcen = 1'b1;
        fields.pwen = 1'b1;
        fields.xcen = 1'b1;
        fields.xwen = 1'b1;

        if (state_q == S_ALD) begin
            xa_full = 16'(act_base_q) + 16'(cnt_q);
        end else begin
            xa_full = 16'(ker_base_q) + 16'(k_q) * 16'(COL) + 16'(cnt_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    act_base_d  = cfg_act_base;
                    ker_base_d  = cfg_ker_base;
                    psum_base_d = cfg_psum_base;
                    act_len_d   = cfg_act_len;
                    out_len_d   = cfg_out_len;
                    relu_d      = cfg_relu;
                    k_d         = '0;
                    cnt_d       = '0;
                    j_d         = '0;
                    sub_d       = 1'b0;
                    state_d     = (cfg_act_len == '0 || cfg_out_len == '0) ? S_FIN : S_KLD;
                end
            end
            S_KLD, S_ALD: begin
                // L0 write trails the xmem read by one cycle (SRAM read latency).
                if (cnt_q < ((state_q == S_KLD) ? LEN_W'(COL) : act_len_q)) begin
                    fields.xcen  = 1'b0;
                    fields.xaddr = xa_full[SRAM_AW-1:0];
                    if (xa_full >= 16'd1024) err_addr_d = 1'b1;
                end
                fields.l0wr = (cnt_q != '0);
                if (cnt_q == ((state_q == S_KLD) ? LEN_W'(COL) : act_len_q)) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_KLD) ? S_KARR : S_EXEC;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_KARR: begin
                fields.l0rd = 1'b1;
                fields.kld  = 1'b1;
                if (cnt_q == LEN_W'(COL - 1)) begin
                    cnt_d   = '0;
                    state_d = S_KGAP;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_KGAP: begin
                state_d = S_ALD;
            end
            S_EXEC: begin
                fields.l0rd = 1'b1;
                fields.exe  = 1'b1;
                if (cnt_q == act_len_q - LEN_W'(1)) begin
                    cnt_d   = '0;
                    j_d     = '0;
                    sub_d   = 1'b0;
                    state_d = S_DRN;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_DRN: begin
                fields.paddr = SRAM_AW'(psum_base_q) + SRAM_AW'(j_q);
                if (k_q == '0) begin
                    if (ofifo_valid) begin
                        fields.ofrd = 1'b1;
                        fields.pcen = 1'b0;
                        fields.pwen = 1'b0;
                        fields.relu = relu_q & last_pass;
                        drain_step  = 1'b1;
                    end else begin
                        fields.paddr = '0;
                    end
                end else if (!sub_q) begin
                    if (ofifo_valid) begin
                        fields.pcen = 1'b0;
                        sub_d       = 1'b1;
                    end else begin
                        fields.paddr = '0;
                    end
                end else begin
                    // Write-back of psum + new output; the word is still at the OFIFO head.
                    fields.ofrd  = 1'b1;
                    fields.accum = 1'b1;
                    fields.pcen  = 1'b0;
                    fields.pwen  = 1'b0;
                    fields.relu  = relu_q & last_pass;
                    sub_d        = 1'b0;
                    drain_step   = 1'b1;
                end
                if (drain_step) begin
                    if (j_q == out_len_q - LEN_W'(1)) begin
                        if (last_pass) begin
                            state_d = S_FIN;
                        end else begin
                            k_d     = k_q + KW'(1);
                            cnt_d   = '0;
                            state_d = S_KLD;
                        end
                    end else begin
                        j_d = j_q + LEN_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    inst_word_pack u_pack (
        .f    (fields),
        .word (inst_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            j_q         <= '0;
            k_q         <= '0;
            sub_q       <= 1'b0;
            err_addr_q  <= 1'b0;
            act_base_q  <= '0;
            ker_base_q  <= '0;
            psum_base_q <= '0;
            act_len_q   <= '0;
            out_len_q   <= '0;
            relu_q      <= 1'b0;
            inst_q      <= INST_IDLE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            k_q         <= k_d;
            sub_q       <= sub_d;
            err_addr_q  <= err_addr_d;
            act_base_q  <= act_base_d;
            ker_base_q  <= ker_base_d;
            psum_base_q <= psum_base_d;
            act_len_q   <= act_len_d;
            out_len_q   <= out_len_d;
            relu_q      <= relu_d;
            inst_q      <= inst_d;
        end
    end

    assign inst = inst_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIN);

`ifdef CORE_INST_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (state_q == S_IDLE && start) begin
            perf_cycles_d = '0;
            perf_stall_d  = '0;
        end else begin
            if (state_q != S_IDLE) perf_cycles_d = perf_cycles_q + 32'd1;
            if (state_q == S_DRN && !ofifo_valid) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: table of full-run streams plus stall, reset and start corner cases.
module tb_core_inst_seq;

    localparam logic [34:0] IDLE_W = 35'h1_800C_0000;
    localparam int COLS = 8;

    logic        clk;
    logic        reset;
    logic        start1, start9;
    logic [10:0] cfg_act_base, cfg_ker_base, cfg_psum_base;
    logic [10:0] cfg_act_len, cfg_out_len;
    logic        cfg_relu;
    logic        ofifo_valid;
    logic [34:0] inst1, inst9;
    logic        busy1, busy9, done1, done9;
`ifdef CORE_INST_SEQ_PERF_EN
    logic [31:0] perf_cycles1, perf_stall1, perf_cycles9, perf_stall9;
`endif

    core_inst_seq #(.COL(COLS), .ADDR_W(11), .NUM_KIJ(1), .LEN_W(11)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .cfg_act_base(cfg_act_base), .cfg_ker_base(cfg_ker_base), .cfg_psum_base(cfg_psum_base),
        .cfg_act_len(cfg_act_len), .cfg_out_len(cfg_out_len), .cfg_relu(cfg_relu),
        .ofifo_valid(ofifo_valid),
`ifdef CORE_INST_SEQ_PERF_EN
        .perf_cycles(perf_cycles1), .perf_stall(perf_stall1),
`endif
        .inst(inst1), .busy(busy1), .done(done1)
    );

    core_inst_seq #(.COL(COLS), .ADDR_W(11), .NUM_KIJ(9), .LEN_W(11)) u_dut9 (
        .clk(clk), .reset(reset), .start(start9),
        .cfg_act_base(cfg_act_base), .cfg_ker_base(cfg_ker_base), .cfg_psum_base(cfg_psum_base),
        .cfg_act_len(cfg_act_len), .cfg_out_len(cfg_out_len), .cfg_relu(cfg_relu),
        .ofifo_valid(ofifo_valid),
`ifdef CORE_INST_SEQ_PERF_EN
        .perf_cycles(perf_cycles9), .perf_stall(perf_stall9),
`endif
        .inst(inst9), .busy(busy9), .done(done9)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];
    logic        vpat[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] w(input logic relu, input logic accum, input logic pcen,
                                      input logic pwen, input int pa, input logic xcen,
                                      input logic xwen, input int xa, input logic ofrd,
                                      input logic l0rd, input logic l0wr, input logic exe,
                                      input logic kld);
        logic [10:0] pa_b;
        logic [10:0] xa_b;
        pa_b = pa[10:0];
        xa_b = xa[10:0];
        return {relu, accum, pcen, pwen, pa_b, xcen, xwen, xa_b, ofrd, 2'b00, l0rd, l0wr, exe, kld};
    endfunction

    // Expected inst stream from the cycle after start through the done cycle, ofifo_valid held high.
    task automatic build_exp(input int nk, input int ker, input int act, input int psum,
                             input int a, input int o, input logic relu);
        exp_q.delete();
        exp_q.push_back(IDLE_W);
        if (a == 0 || o == 0) return;
        for (int k = 0; k < nk; k++) begin
            for (int i = 0; i <= COLS; i++)
                exp_q.push_back(w(0, 0, 1, 1, 0, (i == COLS), 1, (i < COLS) ? ker + k * COLS + i : 0,
                                  0, 0, (i > 0), 0, 0));
            for (int i = 0; i < COLS; i++) exp_q.push_back(w(0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1));
            exp_q.push_back(IDLE_W);
            for (int i = 0; i <= a; i++)
                exp_q.push_back(w(0, 0, 1, 1, 0, (i == a), 1, (i < a) ? act + i : 0, 0, 0, (i > 0), 0, 0));
            for (int i = 0; i < a; i++) exp_q.push_back(w(0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0));
            for (int j = 0; j < o; j++) begin
                if (k > 0) exp_q.push_back(w(0, 0, 0, 1, psum + j, 1, 1, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(w(relu && (k == nk - 1), (k > 0), 0, 0, psum + j, 1, 1, 0, 1, 0, 0, 0, 0));
            end
        end
    endtask

    // Driver: pulse start on one instance and capture inst every cycle until done.
    task automatic run(input int which, input int inj_at);
        int busy_bad;
        logic seen_done;
        busy_bad  = 0;
        seen_done = 1'b0;
        got_q.delete();
        @(posedge clk); #1;
        if (which == 1) start1 = 1'b1; else start9 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start9 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            ofifo_valid = (n < vpat.size()) ? vpat[n] : 1'b1;
            if (n == inj_at) begin
                cfg_out_len = 11'd0;
                if (which == 1) start1 = 1'b1; else start9 = 1'b1;
            end
            @(negedge clk);
            got_q.push_back((which == 1) ? inst1 : inst9);
            if (((which == 1) ? busy1 : busy9) !== 1'b1) busy_bad++;
            if (((which == 1) ? done1 : done9) === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            start1 = 1'b0;
            start9 = 1'b0;
        end
        ofifo_valid = 1'b1;
        check("done_seen", seen_done, 1'b1);
        check("busy_during_run", busy_bad, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_busy", (which == 1) ? busy1 : busy9, 1'b0);
        check("post_done", (which == 1) ? done1 : done9, 1'b0);
        check("post_inst", (which == 1) ? inst1 : inst9, IDLE_W);
    endtask

    task automatic compare_stream(input string name);
        int n;
        check({name, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
    endtask

    typedef struct {
        int   which;
        int   ker;
        int   act;
        int   psum;
        int   a;
        int   o;
        logic relu;
    } vec_t;

    vec_t vecs[5];

    initial begin
        reset = 1'b0; start1 = 1'b0; start9 = 1'b0; ofifo_valid = 1'b1;
        cfg_act_base = '0; cfg_ker_base = '0; cfg_psum_base = '0;
        cfg_act_len = '0; cfg_out_len = '0; cfg_relu = 1'b0;

        vecs[0] = '{which: 1, ker: 0,    act: 100,  psum: 200, a: 16, o: 16, relu: 1'b0};
        vecs[1] = '{which: 9, ker: 0,    act: 40,   psum: 64,  a: 2,  o: 4,  relu: 1'b0};
        vecs[2] = '{which: 9, ker: 16,   act: 8,    psum: 300, a: 1,  o: 2,  relu: 1'b1};
        vecs[3] = '{which: 1, ker: 1020, act: 1000, psum: 5,   a: 3,  o: 2,  relu: 1'b1};
        vecs[4] = '{which: 1, ker: 0,    act: 0,    psum: 0,   a: 0,  o: 3,  relu: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inst1", inst1, IDLE_W);
        check("rst_inst9", inst9, IDLE_W);
        check("rst_busy1", busy1, 1'b0);
        check("rst_done9", done9, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            cfg_ker_base  = 11'(vecs[v].ker);
            cfg_act_base  = 11'(vecs[v].act);
            cfg_psum_base = 11'(vecs[v].psum);
            cfg_act_len   = 11'(vecs[v].a);
            cfg_out_len   = 11'(vecs[v].o);
            cfg_relu      = vecs[v].relu;
            build_exp((vecs[v].which == 1) ? 1 : 9, vecs[v].ker, vecs[v].act, vecs[v].psum,
                      vecs[v].a, vecs[v].o, vecs[v].relu);
            run(vecs[v].which, -1);
            compare_stream($sformatf("vec%0d", v));
        end

        // OFIFO valid pattern 1,0,0,1 across the drain of a single pass.
        cfg_ker_base = 11'd0; cfg_act_base = 11'd50; cfg_psum_base = 11'd90;
        cfg_act_len = 11'd2; cfg_out_len = 11'd2; cfg_relu = 1'b0;
        vpat.delete();
        for (int i = 0; i < 27; i++) vpat.push_back((i == 24 || i == 25) ? 1'b0 : 1'b1);
        run(1, -1);
        vpat.delete();
        check("stall_len", got_q.size(), 28);
        if (got_q.size() == 28) begin
            check("stall_wr0", got_q[24], w(0, 0, 0, 0, 90, 1, 1, 0, 1, 0, 0, 0, 0));
            check("stall_gap0", got_q[25], IDLE_W);
            check("stall_gap1", got_q[26], IDLE_W);
            check("stall_wr1", got_q[27], w(0, 0, 0, 0, 91, 1, 1, 0, 1, 0, 0, 0, 0));
        end
`ifdef CORE_INST_SEQ_PERF_EN
        check("perf_stall", perf_stall1, 32'd2);
        check("perf_cycles", perf_cycles1, 32'd28);
`endif

        // Start pulse mid-run (with out_len changed to 0) must not disturb the run.
        cfg_act_len = 11'd2; cfg_out_len = 11'd2; cfg_relu = 1'b0;
        build_exp(1, 0, 50, 90, 2, 2, 1'b0);
        run(1, 5);
        compare_stream("busy_start");

        // out_len == 0: done the cycle after start, no SRAM access.
        exp_q.delete();
        exp_q.push_back(IDLE_W);
        run(1, -1);
        compare_stream("out_len0");

        // Reset asserted for one cycle during EXEC.
        cfg_act_len = 11'd16; cfg_out_len = 11'd16;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_exec", inst1, w(0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0));
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_inst", inst1, IDLE_W);
        check("mid_rst_busy", busy1, 1'b0);
        begin
            int l0rd_seen;
            l0rd_seen = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (inst1[3] !== 1'b0 || busy1 !== 1'b0) l0rd_seen++;
            end
            check("mid_rst_quiet", l0rd_seen, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
